// File: rtl/mux4_rr_sched_if.sv
// rtl/mux4_rr_sched_if.sv - request/grant/select and output handshake bundle around the 4:1 mux
interface mux4_rr_sched_if #(
  parameter int N = 8
);
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [N-1:0] mux_out;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  // Scheduler side: consumes requests and mux word, produces grant/select and the output stream
  modport slave (
    input  req,
    input  mux_out,
    input  out_ready,
    output gnt,
    output sel,
    output out_data,
    output out_valid
  );

  // Requester/consumer side
  modport master (
    output req,
    output mux_out,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin 4-channel merge with one-entry output register (optional stats: MUX4_RR_STATS_EN)
module mux4_rr_sched #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4_rr_sched_if.slave      bus
`ifdef MUX4_RR_STATS_EN
  ,
  output logic [63:0]         grant_cnt,
  input  logic                stats_clr
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [1:0]   last_ptr;
  logic [N-1:0] data_q;

  logic         can_load;
  logic         found;
  logic         fire;
  logic [1:0]   winner;
  logic [1:0]   cand;
  logic [3:0]   gnt_c;
  logic [1:0]   sel_c;

  // State, captured word and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      data_q   <= '0;
      last_ptr <= 2'b11;
    end else begin
      state <= state_next;
      if (fire) begin
        data_q   <= bus.mux_out;
        last_ptr <= winner;
      end
    end
  end

  // Arbitration starting after the last winner, grant/select and next state
  always_comb begin
    can_load = (state == EMPTY) || bus.out_ready;
    winner   = last_ptr;
    found    = 1'b0;
    cand     = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      cand = last_ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    fire = can_load && found;

    gnt_c = 4'b0000;
    sel_c = last_ptr;  // hold select steady when idle so the mux output does not toggle
    if (fire) begin
      gnt_c = 4'b0001 << winner;
      sel_c = winner;
    end

    state_next = state;
    if (fire) begin
      state_next = FULL;
    end else if ((state == FULL) && bus.out_ready) begin
      state_next = EMPTY;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.sel       = sel_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state == FULL);

`ifdef MUX4_RR_STATS_EN
  logic [15:0] cnt [4];

  // Per-channel saturating grant counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= 16'h0000;
      end
    end else if (stats_clr) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (gnt_c[i] && (cnt[i] != 16'hFFFF)) begin
          cnt[i] <= cnt[i] + 16'h0001;
        end
      end
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb/tb_mux4_rr_sched.sv - self-checking bench for mux4_rr_sched against a behavioural model
`timescale 1ns/1ps
module tb_mux4_rr_sched;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  mux4_rr_sched_if #(.N(N)) bus ();

  logic [N-1:0] mux_in [4];

`ifdef MUX4_RR_STATS_EN
  logic [63:0] grant_cnt;
  logic        stats_clr;
  int          m_cnt [4];
`endif

  mux4_rr_sched #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MUX4_RR_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stats_clr (stats_clr)
`endif
  );

  // The mux itself lives outside the scheduler
  assign bus.mux_out = mux_in[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference state
  bit     m_valid;
  int     m_data;
  int     m_last;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_last  = 3;
`ifdef MUX4_RR_STATS_EN
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
`endif
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
    chk({tag, ".out_data"},  64'(bus.out_data),  64'(m_data));
`ifdef MUX4_RR_STATS_EN
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.cnt%0d", tag, i), 64'(grant_cnt[16*i +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge
  task automatic step(input string tag, input logic [3:0] r, input logic rdy, input bit do_chk);
    int  win;
    bit  fire;
    int  exp_gnt;
    int  exp_sel;
    bus.req       = r;
    bus.out_ready = rdy;
    #1;
    win  = -1;
    for (int k = 1; k <= 4; k++) begin
      if (win < 0 && r[(m_last + k) % 4]) win = (m_last + k) % 4;
    end
    fire    = (!m_valid || rdy) && (win >= 0);
    exp_gnt = fire ? (1 << win) : 0;
    exp_sel = fire ? win : m_last;
    if (do_chk) begin
      chk({tag, ".gnt"}, 64'(bus.gnt), 64'(exp_gnt));
      chk({tag, ".sel"}, 64'(bus.sel), 64'(exp_sel));
      check_regs(tag);
    end
    @(posedge clk);
    if (fire) begin
      m_data  = int'(mux_in[win]);
      m_valid = 1'b1;
      m_last  = win;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
`ifdef MUX4_RR_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (fire && m_cnt[win] < 16'hFFFF) begin
      m_cnt[win] = m_cnt[win] + 1;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) mux_in[i] = N'(8'hA0 + i);
`ifdef MUX4_RR_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();

    // Reset then idle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst.gnt", 64'(bus.gnt), 64'd0);
      chk("rst.sel", 64'(bus.sel), 64'd3);
      check_regs("rst");
    end
    rst_n = 1'b1;
    step("idle", 4'b0000, 1'b1, 1'b1);

    // Round-robin at full throughput
    for (int c = 0; c < 6; c++) step("rr", 4'b1111, 1'b1, 1'b1);
    step("rr_drain", 4'b0000, 1'b1, 1'b1);

    // Backpressure with a pending request, then drain and reload together
    step("bp_load", 4'b0100, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step("bp_stall", 4'b0100, 1'b0, 1'b1);
    step("bp_stall_newreq", 4'b1011, 1'b0, 1'b1);
    step("bp_release", 4'b0100, 1'b1, 1'b1);

    // Skip and wrap: pointer at 2, channels 0 and 1 requesting
    step("wrap", 4'b0011, 1'b1, 1'b1);
    step("wrap2", 4'b0011, 1'b1, 1'b1);

    // Asynchronous reset while holding a word
    step("pre_rst", 4'b1000, 1'b0, 1'b1);
    step("pre_rst2", 4'b0000, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst.out_data",  64'(bus.out_data),  64'd0);
    chk("arst.sel",       64'(bus.sel),       64'd3);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 4'b1111, 1'b1, 1'b1);
    step("post_rst2", 4'b1111, 1'b1, 1'b1);

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) mux_in[i] = N'($urandom);
      step("rand", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'b1);
    end

`ifdef MUX4_RR_STATS_EN
    // Counter increment, clear priority and saturation
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) step("st_inc", 4'b0100, 1'b1, 1'b1);
    chk("st_five", 64'(grant_cnt[47:32]), 64'd5);
    stats_clr = 1'b1;
    step("st_clr", 4'b0100, 1'b1, 1'b1);
    stats_clr = 1'b0;
    chk("st_zero", 64'(grant_cnt[47:32]), 64'd0);
    for (int c = 0; c < 65540; c++) step("st_sat", 4'b0100, 1'b1, 1'b0);
    check_regs("st_sat_end");
    chk("st_sat", 64'(grant_cnt[47:32]), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
